// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the hidden-layer neuron lanes.
//   U_W      : default potential width (signed two's complement)
//   sat_min  : most negative representable potential for a given width
//   sat_max  : most positive representable potential for a given width
//   sat_add  : signed add clamped to the representable range of a width
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int unsigned U_W = 8;

    localparam int SAT_MIN = -(1 <<< (U_W - 1));
    localparam int SAT_MAX = (1 <<< (U_W - 1)) - 1;

    function automatic int sat_min(input int unsigned width);
        return -(1 <<< (width - 1));
    endfunction

    function automatic int sat_max(input int unsigned width);
        return (1 <<< (width - 1)) - 1;
    endfunction

    // Operands are sign-extended ints, so the sum can never wrap before clamping.
    function automatic int sat_add(input int a, input int b, input int unsigned width = U_W);
        int sum;
        sum = a + b;
        if (sum > sat_max(width)) begin
            return sat_max(width);
        end else if (sum < sat_min(width)) begin
            return sat_min(width);
        end
        return sum;
    endfunction

endpackage

// File: rtl/snn_lane.sv
// ---------------------------------------------------------------------------
// snn_lane
// One synaptic accumulator plus one membrane-potential register.
//   clk                   : rising-edge clock
//   reset                 : asynchronous active-high reset, clears both registers
//   acc_clear             : synchronous accumulator clear (drops this cycle's spikes)
//   neu_clear             : synchronous membrane clear (beats ien)
//   acc_oen               : gates the accumulator onto accumulated_potential
//   w                     : two weight bits, 1 = +1, 0 = -1
//   spk                   : two input spikes
//   ien                   : membrane load enable
//   potential_previous    : decayed previous potential to merge with
//   accumulated_potential : gated accumulator value (combinational)
//   potential_final       : registered membrane potential
// ---------------------------------------------------------------------------
module snn_lane
    import snn_pkg::*;
#(
    parameter int unsigned WIDTH = snn_pkg::U_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    acc_clear,
    input  logic                    neu_clear,
    input  logic                    acc_oen,
    input  logic [1:0]              w,
    input  logic [1:0]              spk,
    input  logic                    ien,
    input  logic signed [WIDTH-1:0] potential_previous,
    output logic signed [WIDTH-1:0] accumulated_potential,
    output logic signed [WIDTH-1:0] potential_final
);

    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] acc_d;
    logic signed [WIDTH-1:0] pot_q;
    logic signed [WIDTH-1:0] pot_d;
    int                      contrib;

    // Per-cycle synaptic contribution in [-2, +2].
    always_comb begin
        contrib = 0;
        for (int j = 0; j < 2; j++) begin
            if (spk[j]) begin
                contrib = w[j] ? contrib + 1 : contrib - 1;
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (acc_clear) begin
            acc_d = '0;
        end else begin
            acc_d = WIDTH'(sat_add(int'(acc_q), contrib, WIDTH));
        end
    end

    assign accumulated_potential = acc_oen ? acc_q : '0;

    // Uses the pre-clear accumulator, so acc_clear + ien hands the sum off on one edge.
    always_comb begin
        pot_d = pot_q;
        if (neu_clear) begin
            pot_d = '0;
        end else if (ien) begin
            pot_d = WIDTH'(sat_add(int'(potential_previous), int'(accumulated_potential), WIDTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            pot_q <= '0;
        end else begin
            acc_q <= acc_d;
            pot_q <= pot_d;
        end
    end

    assign potential_final = pot_q;

endmodule

// File: rtl/snn_neuron_lane_array.sv
// ---------------------------------------------------------------------------
// snn_neuron_lane_array
// LANES independent accumulator + membrane lanes forming the hidden-layer core.
//   clk                   : rising-edge clock
//   reset                 : asynchronous active-high reset
//   acc_clear             : synchronous clear of all accumulators
//   neu_clear             : synchronous clear of all membrane registers
//   acc_oen               : accumulator output enable (all lanes)
//   w_read                : weight bits, lane k uses [2k+1:2k]
//   spk_in                : input spikes, lane k uses [2k+1:2k]
//   ien                   : per-lane potential load enable
//   potential_previous    : previous potential, lane k uses [U_W*k +: U_W]
//   accumulated_potential : gated accumulator, lane k at [U_W*k +: U_W]
//   potential_final       : membrane potential, lane k at [U_W*k +: U_W]
// ---------------------------------------------------------------------------
module snn_neuron_lane_array
    import snn_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned U_W   = snn_pkg::U_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_clear,
    input  logic                 neu_clear,
    input  logic                 acc_oen,
    input  logic [2*LANES-1:0]   w_read,
    input  logic [2*LANES-1:0]   spk_in,
    input  logic [LANES-1:0]     ien,
    input  logic [U_W*LANES-1:0] potential_previous,
    output logic [U_W*LANES-1:0] accumulated_potential,
    output logic [U_W*LANES-1:0] potential_final
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [U_W-1:0] prev;
        logic signed [U_W-1:0] acc_out;
        logic signed [U_W-1:0] pot_out;

        assign prev = potential_previous[U_W*k +: U_W];

        snn_lane #(
            .WIDTH (U_W)
        ) u_lane (
            .clk                   (clk),
            .reset                 (reset),
            .acc_clear             (acc_clear),
            .neu_clear             (neu_clear),
            .acc_oen               (acc_oen),
            .w                     (w_read[2*k +: 2]),
            .spk                   (spk_in[2*k +: 2]),
            .ien                   (ien[k]),
            .potential_previous    (prev),
            .accumulated_potential (acc_out),
            .potential_final       (pot_out)
        );

        assign accumulated_potential[U_W*k +: U_W] = acc_out;
        assign potential_final[U_W*k +: U_W]       = pot_out;
    end

endmodule

// File: tb/tb_snn_neuron_lane_array.sv
module tb_snn_neuron_lane_array;

    localparam int LANES = 16;
    localparam int U_W   = 8;
    localparam int PMAX  = 127;
    localparam int PMIN  = -128;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 acc_clear = 1'b0;
    logic                 neu_clear = 1'b0;
    logic                 acc_oen = 1'b0;
    logic [2*LANES-1:0]   w_read = '0;
    logic [2*LANES-1:0]   spk_in = '0;
    logic [LANES-1:0]     ien = '0;
    logic [U_W*LANES-1:0] potential_previous = '0;
    logic [U_W*LANES-1:0] accumulated_potential;
    logic [U_W*LANES-1:0] potential_final;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers per lane.
    int m_acc [LANES];
    int m_pot [LANES];

    snn_neuron_lane_array #(
        .LANES (LANES),
        .U_W   (U_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .acc_clear             (acc_clear),
        .neu_clear             (neu_clear),
        .acc_oen               (acc_oen),
        .w_read                (w_read),
        .spk_in                (spk_in),
        .ien                   (ien),
        .potential_previous    (potential_previous),
        .accumulated_potential (accumulated_potential),
        .potential_final       (potential_final)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    function automatic int acc_of(input int k);
        logic signed [U_W-1:0] v;
        v = accumulated_potential[U_W*k +: U_W];
        return int'(v);
    endfunction

    function automatic int pot_of(input int k);
        logic signed [U_W-1:0] v;
        v = potential_final[U_W*k +: U_W];
        return int'(v);
    endfunction

    function automatic int prev_of(input int k);
        logic signed [U_W-1:0] v;
        v = potential_previous[U_W*k +: U_W];
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_acc[k] = 0;
            m_pot[k] = 0;
        end
    endtask

    // Apply one clock edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        for (int k = 0; k < LANES; k++) begin
            int d;
            int visible;
            d = 0;
            for (int j = 0; j < 2; j++) begin
                if (spk_in[2*k+j]) d += w_read[2*k+j] ? 1 : -1;
            end
            visible = acc_oen ? m_acc[k] : 0;
            if (neu_clear)   m_pot[k] = 0;
            else if (ien[k]) m_pot[k] = clamp(prev_of(k) + visible);
            m_acc[k] = acc_clear ? 0 : clamp(m_acc[k] + d);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("acc%0d", k), acc_of(k), acc_oen ? m_acc[k] : 0);
            check($sformatf("pot%0d", k), pot_of(k), m_pot[k]);
        end
    endtask

    // Model the edge, let the DUT take it, then sample 1 time unit later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        acc_clear          = 1'b0;
        neu_clear          = 1'b0;
        w_read             = '0;
        spk_in             = '0;
        ien                = '0;
        potential_previous = '0;
    endtask

    task automatic randomize_inputs();
        w_read    = $urandom;
        spk_in    = $urandom;
        ien       = LANES'($urandom);
        acc_oen   = ($urandom_range(0, 3) != 0);
        acc_clear = ($urandom_range(0, 15) == 0);
        neu_clear = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < LANES; k++) begin
            potential_previous[U_W*k +: U_W] = U_W'($urandom);
        end
    endtask

    task automatic lane0(input logic [1:0] w, input logic [1:0] s);
        w_read[1:0] = w;
        spk_in[1:0] = s;
    endtask

    initial begin
        model_reset();

        // Async reset: outputs clear before any clock edge.
        randomize_inputs();
        #1;
        reset = 1'b1;
        #1;
        compare_all();
        check("rst_acc0", acc_of(0), 0);
        check("rst_pot0", pot_of(0), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random phase.
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step();
        end

        // Mid-operation async reset, then resume from zero state.
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            randomize_inputs();
            step();
        end

        // Accumulate on lane 0.
        idle_inputs();
        acc_oen   = 1'b1;
        acc_clear = 1'b1;
        neu_clear = 1'b1;
        step();
        idle_inputs();
        lane0(2'b11, 2'b11);
        step(); check("accum_2", acc_of(0), 2);
        step(); check("accum_4", acc_of(0), 4);
        step(); check("accum_6", acc_of(0), 6);
        lane0(2'b01, 2'b10);
        step(); check("accum_5", acc_of(0), 5);

        // Saturation at both rails.
        lane0(2'b11, 2'b11);
        for (int i = 0; i < 70; i++) step();
        check("sat_hi", acc_of(0), 127);
        lane0(2'b00, 2'b11);
        for (int i = 0; i < 130; i++) step();
        check("sat_lo", acc_of(0), -128);

        // Output gating.
        idle_inputs();
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        lane0(2'b11, 2'b11);
        for (int i = 0; i < 3; i++) step();
        lane0(2'b00, 2'b00);
        acc_oen = 1'b0;
        #1;
        check("gate_off", acc_of(0), 0);
        ien[0] = 1'b1;
        potential_previous[7:0] = 8'd10;
        step(); check("load_prev", pot_of(0), 10);
        acc_oen = 1'b1;
        step(); check("load_sum", pot_of(0), 16);

        // Neuron saturation and clear priority.
        idle_inputs();
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        lane0(2'b11, 2'b11);
        for (int i = 0; i < 10; i++) step();
        check("acc_20", acc_of(0), 20);
        lane0(2'b00, 2'b00);
        ien[0] = 1'b1;
        potential_previous[7:0] = 8'd120;
        step(); check("pot_sat", pot_of(0), 127);
        neu_clear = 1'b1;
        step(); check("clr_wins", pot_of(0), 0);

        // Same-edge handoff; lane 1 stimulated only in the clearing cycle.
        idle_inputs();
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        lane0(2'b11, 2'b11);
        for (int i = 0; i < 2; i++) step();
        lane0(2'b00, 2'b00);
        acc_clear = 1'b1;
        ien[0] = 1'b1;
        potential_previous[7:0] = 8'd3;
        w_read[3:2] = 2'b11;
        spk_in[3:2] = 2'b11;
        step();
        check("handoff_pot", pot_of(0), 7);
        check("handoff_acc", acc_of(0), 0);
        check("lane1_acc", acc_of(1), 0);
        check("lane1_pot", pot_of(1), 0);
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/snn_neuron_lane_array.md
Name: snn_neuron_lane_array

Overview:
- Array of LANES synaptic-accumulator + membrane-potential lanes: the compute core of the hidden SNN layer.
- Each lane sums binary-weighted input spikes over a timestep, then merges the sum with the previous, decayed potential into a stored membrane potential.
- Sits between the neuron selector (spikes in, previous potentials in, potentials out) and the weight SRAM read port.
- Sequenced entirely by control-unit strobes (clear, output enable, load enable).

Parameters:
- LANES, 16, number of independent lanes.
- U_W, 8, potential width, signed two's complement.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- acc_clear  in  1  synchronous clear of all accumulators (control-unit ac_reset strobe)
- neu_clear  in  1  synchronous clear of all membrane registers
- acc_oen  in  1  accumulator output enable
- w_read  in  2*LANES  weight bits; lane k uses [2k+1:2k]
- spk_in  in  2*LANES  input spikes; lane k uses [2k+1:2k]
- ien  in  LANES  per-lane potential load enable
- potential_previous  in  U_W*LANES  previous potential per lane; lane k uses [U_W*k+U_W-1:U_W*k]
- accumulated_potential  out  U_W*LANES  gated accumulator value per lane
- potential_final  out  U_W*LANES  registered membrane potential per lane

Behaviour:
- Weight encoding: weight bit 1 = +1, weight bit 0 = -1.

Accumulator (per lane):
- Per cycle, contribution d is the sum over j in {0,1} of (spk_in[j] ? (w[j] ? +1 : -1) : 0), so d is in [-2, +2].
- Update priority at posedge:
  - reset (async): acc = 0.
  - else acc_clear: acc <= 0; spikes that cycle are dropped.
  - else acc <= sat(acc + d).
- sat clamps to [-128, +127] for U_W = 8; generally [-2^(U_W-1), 2^(U_W-1)-1]. There is no wrap-around.
- accumulated_potential = acc_oen ? acc : 0. This is combinational, with no added latency.
- A spike presented in cycle n is visible on accumulated_potential after edge n (1-cycle latency).

Neuron (per lane):
- Update priority at posedge:
  - reset (async): potential_final = 0.
  - else neu_clear: potential_final <= 0.
  - else ien[k]: potential_final <= sat(potential_previous + accumulated_potential).
  - else hold.
- Addition is signed, evaluated at U_W+1 bits, then saturated.
- Because accumulated_potential is gated by acc_oen, asserting ien with acc_oen = 0 loads potential_previous unchanged.
- acc_clear and ien in the same cycle: the neuron uses the pre-clear acc value and the accumulator clears. This gives a same-edge handoff.

Reset values:
- All acc = 0 and all potential_final = 0.
- accumulated_potential = 0.
- Deasserting reset mid-operation resumes from zero state.

General:
- Lanes are fully independent; there are no cross-lane paths.

Decomposition:
- Shared package snn_pkg: U_W, the saturation limits, and a function sat_add(a, b) returning the saturated U_W result.
- Sub-module snn_lane holds one accumulator plus one membrane register.
- The top level is a generate loop over LANES that slices the packed buses.

Test Plan:
1. Reset: assert reset with random inputs. Required: all potential_final = 0 and accumulated_potential = 0, asynchronously, before any clock edge.
2. Accumulate: lane 0, acc_oen = 1, w = 2'b11, spk = 2'b11 for 3 cycles. Required: accumulated_potential[7:0] = 2, 4, 6. Then w = 2'b01, spk = 2'b10 for 1 cycle. Required: 5.
3. Saturation: w = 2'b11, spk = 2'b11 for 70 cycles. Required: acc stops at 127 (0x7F). With w = 2'b00, spk = 2'b11 for 130 cycles. Required: acc stops at -128 (0x80).
4. Output gating: acc = 6, acc_oen = 0. Required: accumulated_potential = 0. Then ien = 1, potential_previous = 10. Required: potential_final = 10. Set acc_oen = 1, ien = 1 again. Required: potential_final = 16.
5. Neuron saturation and clear: previous = 120, acc = 20, ien = 1. Required: potential_final = 127. Then neu_clear = 1 together with ien = 1. Required: potential_final = 0 (clear wins).
6. Handoff: acc = 4, acc_clear = 1 and ien = 1 in the same cycle with previous = 3. Required: potential_final = 7 and acc = 0 afterwards. Lane 1 is stimulated only in this cycle and is unaffected by lane 0 activity.
